// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and default width.
package mult_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mult_control.sv
// Control FSM for the shift-and-add multiplier: sequences load, add, shift and result capture.
module shift_add_mult_control
  import mult_pkg::*;
#(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          q_lsb,
  input  logic [CW-1:0] count,
  output logic          load,
  output logic          add_en,
  output logic          shift,
  output logic          cap_product,
  output logic          busy,
  output logic          done
);

  state_t state, state_next;

  // State register with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and decoded datapath strobes.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    add_en      = 1'b0;
    shift       = 1'b0;
    cap_product = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        busy       = 1'b1;
        add_en     = q_lsb;
        state_next = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (count == CW'(1)) begin
          cap_product = 1'b1;
          state_next  = DONE;
        end else begin
          state_next = ADD;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier: datapath registers plus control FSM instance.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    multiplicando,
  input  logic [N-1:0]    multiplicador,
  output logic [N:0]      regA,
  output logic [N-1:0]    regQ,
  output logic [CW-1:0]   count,
  output logic [2*N-1:0]  product,
  output logic            busy,
  output logic            done
);

  logic [N-1:0] m;
  logic         load;
  logic         add_en;
  logic         shift;
  logic         cap_product;

  shift_add_mult_control #(
    .CW(CW)
  ) u_control (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .q_lsb       (regQ[0]),
    .count       (count),
    .load        (load),
    .add_en      (add_en),
    .shift       (shift),
    .cap_product (cap_product),
    .busy        (busy),
    .done        (done)
  );

  // Datapath registers: operand capture, conditional add, right shift and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      regA    <= '0;
      regQ    <= '0;
      m       <= '0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      m     <= multiplicando;
      regQ  <= multiplicador;
      regA  <= '0;
      count <= CW'(N);
    end else if (add_en) begin
      regA <= {1'b0, regA[N-1:0]} + {1'b0, m};
    end else if (shift) begin
      {regA, regQ} <= {1'b0, regA, regQ[N-1:1]};
      count        <= count - CW'(1);
      // Low 2N bits of the post-shift {regA, regQ}; carry bit lands on top.
      if (cap_product) product <= {regA, regQ[N-1:1]};
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult (N=4).
module tb_shift_add_mult;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N-1:0]    multiplicando;
  logic [N-1:0]    multiplicador;
  logic [N:0]      regA;
  logic [N-1:0]    regQ;
  logic [CW-1:0]   count;
  logic [2*N-1:0]  product;
  logic            busy;
  logic            done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  shift_add_mult #(
    .N(N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .regA          (regA),
    .regQ          (regQ),
    .count         (count),
    .product       (product),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from IDLE; cycle k is observed after the k-th edge.
  // Ends in IDLE (cycle 10).
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int unsigned exp, output bit carry_seen, output bit a_nonzero);
    carry_seen = 1'b0;
    a_nonzero  = 1'b0;
    start = 1'b1;
    multiplicando = a;
    multiplicador = b;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc == 1) begin
        start = 1'b0;
        multiplicando = ~a;
        multiplicador = ~b;
      end
      chk($sformatf("%s busy c%0d", name, cyc), busy, (cyc <= 8) ? 1 : 0);
      chk($sformatf("%s done c%0d", name, cyc), done, (cyc == 9) ? 1 : 0);
      if (regA[N]) carry_seen = 1'b1;
      if (regA != '0) a_nonzero = 1'b1;
    end
    chk({name, " product"}, product, exp);
    chk({name, " regA carry"}, regA[N], 0);
    chk({name, " count"}, count, 0);
    tick();
    chk({name, " idle busy"}, busy, 0);
    chk({name, " idle count"}, count, 0);
  endtask

  bit carry_seen, a_nonzero, saw_done;
  int unsigned done_hits;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    tick();
    tick();
    chk("reset regA", regA, 0);
    chk("reset regQ", regQ, 0);
    chk("reset count", count, 0);
    chk("reset product", product, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst = 1'b0;
    tick();

    // Basic 6x7
    run_op("6x7", 4'd6, 4'd7, 42, carry_seen, a_nonzero);

    // Carry path: regA goes to 22 (carry set) in the second ADD, cycle 3
    run_op("15x15", 4'd15, 4'd15, 225, carry_seen, a_nonzero);
    chk("15x15 carry seen", carry_seen, 1);

    run_op("0x9", 4'd0, 4'd9, 0, carry_seen, a_nonzero);
    chk("0x9 regA stays zero", a_nonzero, 0);
    run_op("9x1", 4'd9, 4'd1, 9, carry_seen, a_nonzero);
    run_op("1x0", 4'd1, 4'd0, 0, carry_seen, a_nonzero);

    // Ignored start: pulses in cycle 3 and in DONE (cycle 9)
    start = 1'b1;
    multiplicando = 4'd6;
    multiplicador = 4'd7;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 3 || cyc == 9) begin
        start = 1'b1;
        multiplicando = 4'd2;
        multiplicador = 4'd3;
      end
      if (cyc == 9) chk("ign done c9", done, 1);
      if (cyc == 9) chk("ign product", product, 42);
      if (cyc >= 10) chk($sformatf("ign busy c%0d", cyc), busy, 0);
      if (cyc >= 10) chk($sformatf("ign done c%0d", cyc), done, 0);
    end
    chk("ign product held", product, 42);

    // Reset mid-operation
    start = 1'b1;
    multiplicando = 4'd13;
    multiplicador = 4'd11;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst regA", regA, 0);
    chk("midrst regQ", regQ, 0);
    chk("midrst count", count, 0);
    chk("midrst product", product, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst no activity", saw_done, 0);
    run_op("3x5", 4'd3, 4'd5, 15, carry_seen, a_nonzero);

    // Back-to-back with start held; operands a=(3k+5)%16, b=(7k+2)%16.
    // Accepts at k=0 (5x2=10) and k=10 (3x8=24).
    done_hits = 0;
    for (int k = 0; k <= 18; k++) begin
      start = 1'b1;
      multiplicando = 4'((3 * k + 5) % 16);
      multiplicador = 4'((7 * k + 2) % 16);
      tick();
      chk($sformatf("b2b done c%0d", k + 1), done, (k + 1 == 9 || k + 1 == 19) ? 1 : 0);
      if (k + 1 == 9)  chk("b2b product 1", product, 10);
      if (k + 1 == 19) chk("b2b product 2", product, 24);
      if (done) done_hits++;
    end
    start = 1'b0;
    chk("b2b result count", done_hits, 2);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
